// File: rtl/spi_flash_responder.sv
// spi_flash_responder
//   Plays the SPI flash device role (mode 0, single-bit) toward a SoC flash
//   controller. It decodes READ (0x03), FAST READ (0x0B, 8 dummy clocks) and
//   JEDEC-ID (0x9F), and serves data bytes from a byte-wide memory read port.
//   The pad signals are oversampled on wb_clk_i through 2-FF synchronizers.
//
// Ports
//   wb_clk_i       system / oversampling clock
//   wb_rst_i       synchronous active-high reset
//   flash_csb      chip select, active-low (asynchronous)
//   flash_clk      SPI clock, mode 0 (asynchronous)
//   flash_io0      controller-to-flash data
//   flash_io1_do   flash-to-controller data
//   flash_io1_oeb  io1 output enable, active-low (1 = hi-Z)
//   mem_addr       memory byte address
//   mem_rd         one-cycle read strobe
//   mem_rdata      read data, valid one cycle after mem_rd
//   busy           synchronized csb inverted, registered
//   cmd_err        one-cycle pulse on an unsupported opcode
//
// ADDR_W must not exceed 24 (the address phase always carries 24 bits).
module spi_flash_responder #(
   parameter int          ADDR_W   = 24,
   parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              flash_csb,
   input  logic              flash_clk,
   input  logic              flash_io0,
   output logic              flash_io1_do,
   output logic              flash_io1_oeb,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [7:0]        mem_rdata,
   output logic              busy,
   output logic              cmd_err
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA, ST_ID, ST_IGNORE
   } state_t;

   // synchronizers; sck gets a third stage used only for edge detection
   logic csb_s1_q, csb_s2_q;
   logic sck_s1_q, sck_s2_q, sck_s3_q;
   logic io0_s1_q, io0_s2_q;

   state_t            state_q, state_d;
   logic [4:0]        cnt_q, cnt_d;
   logic [23:0]       sh_q, sh_d;
   logic              fast_q, fast_d;
   logic [7:0]        tx_q, tx_d;
   logic [7:0]        pref_q, pref_d;
   logic              rd_pend_q, rd_pend_d;
   logic [1:0]        id_idx_q, id_idx_d;
   logic              io1_q, io1_d;
   logic              oeb_q, oeb_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_rd_q, mem_rd_d;
   logic              busy_q, busy_d;
   logic              cmd_err_q, cmd_err_d;

   logic              csb_sync, sck_rise, sck_fall;
   logic [23:0]       shifted;
   logic [7:0]        id_byte;

   assign csb_sync = csb_s2_q;
   assign sck_rise = sck_s2_q & ~sck_s3_q;
   assign sck_fall = ~sck_s2_q & sck_s3_q;
   assign shifted  = {sh_q[22:0], io0_s2_q};

   always_comb begin
      case (id_idx_q)
         2'd0:    id_byte = JEDEC_ID[23:16];
         2'd1:    id_byte = JEDEC_ID[15:8];
         default: id_byte = JEDEC_ID[7:0];
      endcase
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sh_d       = sh_q;
      fast_d     = fast_q;
      tx_d       = tx_q;
      id_idx_d   = id_idx_q;
      io1_d      = io1_q;
      oeb_d      = oeb_q;
      mem_addr_d = mem_addr_q;
      mem_rd_d   = 1'b0;
      cmd_err_d  = 1'b0;
      busy_d     = ~csb_sync;
      // memory answers one cycle after the strobe; capture it the cycle after
      rd_pend_d  = mem_rd_q;
      pref_d     = rd_pend_q ? mem_rdata : pref_q;

      case (state_q)
         ST_IDLE: begin
            if (!csb_sync) begin
               state_d = ST_CMD;
               cnt_d   = 5'd0;
            end
         end
         ST_CMD: begin
            if (sck_rise) begin
               sh_d  = shifted;
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd7) begin
                  cnt_d = 5'd0;
                  case (shifted[7:0])
                     8'h03: begin state_d = ST_ADDR; fast_d = 1'b0; end
                     8'h0B: begin state_d = ST_ADDR; fast_d = 1'b1; end
                     8'h9F: begin state_d = ST_ID; id_idx_d = 2'd0; end
                     default: begin
                        state_d   = ST_IGNORE;
                        cmd_err_d = 1'b1;
                     end
                  endcase
               end
            end
         end
         ST_ADDR: begin
            if (sck_rise) begin
               sh_d  = shifted;
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd23) begin
                  cnt_d      = 5'd0;
                  mem_addr_d = shifted[ADDR_W-1:0];
                  if (fast_q) begin
                     state_d = ST_DUMMY;
                  end else begin
                     state_d  = ST_DATA;
                     mem_rd_d = 1'b1;
                  end
               end
            end
         end
         ST_DUMMY: begin
            if (sck_rise) begin
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd7) begin
                  cnt_d    = 5'd0;
                  state_d  = ST_DATA;
                  mem_rd_d = 1'b1;
               end
            end
         end
         ST_DATA, ST_ID: begin
            if (sck_fall) begin
               // low 3 bits count falls within a byte; 0 marks a byte boundary
               cnt_d = {2'b00, cnt_q[2:0] + 3'd1};
               if (cnt_q[2:0] == 3'd0) begin
                  oeb_d = 1'b0;
                  if (state_q == ST_DATA) begin
                     tx_d       = pref_q;
                     io1_d      = pref_q[7];
                     mem_addr_d = mem_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                     mem_rd_d   = 1'b1;
                  end else begin
                     tx_d     = id_byte;
                     io1_d    = id_byte[7];
                     id_idx_d = (id_idx_q == 2'd2) ? 2'd0 : id_idx_q + 2'd1;
                  end
               end else begin
                  tx_d  = {tx_q[6:0], 1'b0};
                  io1_d = tx_q[6];
               end
            end
         end
         default: ; // ST_IGNORE: wait for csb high
      endcase

      // deselect overrides everything, including a same-cycle SCK edge
      if (csb_sync) begin
         state_d  = ST_IDLE;
         oeb_d    = 1'b1;
         cnt_d    = 5'd0;
         mem_rd_d = 1'b0;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         csb_s1_q   <= 1'b1;
         csb_s2_q   <= 1'b1;
         sck_s1_q   <= 1'b0;
         sck_s2_q   <= 1'b0;
         sck_s3_q   <= 1'b0;
         io0_s1_q   <= 1'b0;
         io0_s2_q   <= 1'b0;
         state_q    <= ST_IDLE;
         cnt_q      <= 5'd0;
         sh_q       <= 24'd0;
         fast_q     <= 1'b0;
         tx_q       <= 8'd0;
         pref_q     <= 8'd0;
         rd_pend_q  <= 1'b0;
         id_idx_q   <= 2'd0;
         io1_q      <= 1'b0;
         oeb_q      <= 1'b1;
         mem_addr_q <= '0;
         mem_rd_q   <= 1'b0;
         busy_q     <= 1'b0;
         cmd_err_q  <= 1'b0;
      end else begin
         csb_s1_q   <= flash_csb;
         csb_s2_q   <= csb_s1_q;
         sck_s1_q   <= flash_clk;
         sck_s2_q   <= sck_s1_q;
         sck_s3_q   <= sck_s2_q;
         io0_s1_q   <= flash_io0;
         io0_s2_q   <= io0_s1_q;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sh_q       <= sh_d;
         fast_q     <= fast_d;
         tx_q       <= tx_d;
         pref_q     <= pref_d;
         rd_pend_q  <= rd_pend_d;
         id_idx_q   <= id_idx_d;
         io1_q      <= io1_d;
         oeb_q      <= oeb_d;
         mem_addr_q <= mem_addr_d;
         mem_rd_q   <= mem_rd_d;
         busy_q     <= busy_d;
         cmd_err_q  <= cmd_err_d;
      end
   end

   assign flash_io1_do  = io1_q;
   assign flash_io1_oeb = oeb_q;
   assign mem_addr      = mem_addr_q;
   assign mem_rd        = mem_rd_q;
   assign busy          = busy_q;
   assign cmd_err       = cmd_err_q;

endmodule
